// File: rtl/tcp_pkt_arbiter_if.sv
// ---------------------------------------------------------------------------
// tcp_pkt_arbiter_if
// One NetFPGA-style word stream: a data word, its control byte(s), a write
// strobe from the producer and a ready flag from the consumer.
//
// Signals:
//   data  DATA_WIDTH  word carried by the stream
//   ctrl  CTRL_WIDTH  control word (non-zero marks header / end-of-packet)
//   wr    1           producer presents a word this cycle
//   rdy   1           consumer can take a word
//
// Modports:
//   master  the side that produces words (drives data/ctrl/wr, reads rdy)
//   slave   the side that consumes words (reads data/ctrl/wr, drives rdy)
// ---------------------------------------------------------------------------
interface tcp_pkt_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] data;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic                  wr;
    logic                  rdy;

    modport master (output data, output ctrl, output wr, input rdy);
    modport slave  (input data, input ctrl, input wr, output rdy);
endinterface

// File: rtl/tcp_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// tcp_pkt_arbiter
// Packet-granular two-input arbiter in front of the output queues. Input 0
// carries forwarded traffic from the TCP state-machine stage, input 1 carries
// locally generated control packets (ACK injection). Each input is buffered
// in a fall-through FIFO and whole packets are granted, so words from the two
// inputs never interleave on the output.
//
// Ports:
//   clk       single clock, rising edge
//   reset_n   asynchronous, active-low reset (flushes both FIFOs)
//   in0, in1  input streams (slave); rdy = FIFO not full
//   out       output stream (master); wr = word transferred this cycle,
//             rdy = downstream can accept; data/ctrl are the granted head
//   pkt_cnt0  packets forwarded from input 0 (32-bit, wraps)
//   pkt_cnt1  packets forwarded from input 1 (32-bit, wraps)
//
// Configuration:
//   TCP_ARB_STRICT_PRIO_EN  when defined, input 1 always wins in IDLE if it
//                           has a word waiting; otherwise grants alternate
//                           round-robin between packets.
// ---------------------------------------------------------------------------
module tcp_pkt_arbiter #(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int FIFO_DEPTH_BITS = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    tcp_pkt_arbiter_if.slave  in0,
    tcp_pkt_arbiter_if.slave  in1,
    tcp_pkt_arbiter_if.master out,
    output logic [31:0]       pkt_cnt0,
    output logic [31:0]       pkt_cnt1
);
    localparam int DEPTH  = 1 << FIFO_DEPTH_BITS;
    localparam int WORD_W = DATA_WIDTH + CTRL_WIDTH;
    localparam logic [FIFO_DEPTH_BITS:0] FULL_COUNT = DEPTH[FIFO_DEPTH_BITS:0];

    typedef enum logic {IDLE, XFER} state_t;

    state_t state_q, state_d;
    logic   grant_q, grant_d;
    logic   seen_data_q;
    logic   pick;
    logic   xfer;
    logic   eop;

    logic [1:0]        empty;
    logic [1:0]        full;
    logic [1:0]        wr_en;
    logic [1:0]        rd_en;
    logic [WORD_W-1:0] wr_word [2];
    logic [WORD_W-1:0] head    [2];
    logic [WORD_W-1:0] head_g;
    logic [CTRL_WIDTH-1:0] head_ctrl;

    assign wr_word[0] = {in0.data, in0.ctrl};
    assign wr_word[1] = {in1.data, in1.ctrl};

    // Writes into a full FIFO are simply dropped; rdy tells upstream to stop.
    assign wr_en   = {in1.wr & ~full[1], in0.wr & ~full[0]};
    assign in0.rdy = ~full[0];
    assign in1.rdy = ~full[1];

    // Per-input fall-through FIFO: the head word is visible combinationally
    // the cycle after it is written.
    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [WORD_W-1:0]          mem [DEPTH];
        logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
        logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
        logic [FIFO_DEPTH_BITS:0]   count;

        always_ff @(posedge clk) begin
            if (wr_en[g]) begin
                mem[wr_ptr] <= wr_word[g];
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr_en[g]) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (rd_en[g]) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({wr_en[g], rd_en[g]})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end

        assign empty[g] = (count == '0);
        assign full[g]  = (count == FULL_COUNT);
        assign head[g]  = mem[rd_ptr];
    end

    assign head_g    = head[grant_q];
    assign head_ctrl = head_g[CTRL_WIDTH-1:0];
    assign out.data  = head_g[WORD_W-1:CTRL_WIDTH];
    assign out.ctrl  = head_ctrl;
    assign out.wr    = xfer;
    assign rd_en     = {xfer & grant_q, xfer & ~grant_q};

`ifdef TCP_ARB_STRICT_PRIO_EN
    // Input 1 wins whenever it has anything queued.
    assign pick = ~empty[1];
`else
    logic last_q;

    // On a tie the input that did not send the previous packet wins;
    // otherwise whichever FIFO holds data is taken.
    assign pick = (!empty[0] && !empty[1]) ? ~last_q : empty[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else if (eop) begin
            last_q <= grant_q;
        end
    end
`endif

    // EOP is the first non-zero ctrl word after at least one payload word,
    // so a packet can have several header words before its payload.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        xfer    = 1'b0;
        eop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (empty != 2'b11) begin
                    grant_d = pick;
                    state_d = XFER;
                end
            end
            XFER: begin
                xfer = ~empty[grant_q] & out.rdy;
                if (xfer && (head_ctrl != '0) && seen_data_q) begin
                    eop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            seen_data_q <= 1'b0;
            pkt_cnt0    <= '0;
            pkt_cnt1    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            if (eop) begin
                seen_data_q <= 1'b0;
            end else if (xfer && (head_ctrl == '0)) begin
                seen_data_q <= 1'b1;
            end
            if (eop && !grant_q) begin
                pkt_cnt0 <= pkt_cnt0 + 32'd1;
            end
            if (eop && grant_q) begin
                pkt_cnt1 <= pkt_cnt1 + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_tcp_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tcp_pkt_arbiter
// Self-checking bench for tcp_pkt_arbiter. Packets are built per input and,
// when stimulus is issued, pushed into a single expected-word queue in the
// order whole packets should leave the arbiter. A monitor pops and compares
// each word the DUT presents with out.wr.
// ---------------------------------------------------------------------------
module tb_tcp_pkt_arbiter;
    localparam int DW = 64;
    localparam int CW = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
    } word_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] cnt0;
    logic [31:0] cnt1;

    always #5 clk = ~clk;

    tcp_pkt_arbiter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) in0_if ();
    tcp_pkt_arbiter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) in1_if ();
    tcp_pkt_arbiter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) out_if ();

    tcp_pkt_arbiter #(
        .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .FIFO_DEPTH_BITS(3)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .in0(in0_if),
        .in1(in1_if),
        .out(out_if),
        .pkt_cnt0(cnt0),
        .pkt_cnt1(cnt1)
    );

    word_t       stage0[$], stage1[$], copy0[$], copy1[$], expQ[$];
    word_t       monGot, monWant;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          startCyc = 0;
    bit          logging = 1'b0;
    int          cycLog[$];
    int          rdyMode = 0;
    bit          toggleBit = 1'b1;
    bit          modelLast = 1'b1;
    logic [31:0] modelCnt[2];

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready pattern: 0 = stalled, 1 = open, 2 = alternate, 3 = random.
    initial out_if.rdy = 1'b0;
    always @(posedge clk) begin
        #1;
        case (rdyMode)
            0: out_if.rdy = 1'b0;
            1: out_if.rdy = 1'b1;
            2: begin
                out_if.rdy = toggleBit;
                toggleBit  = ~toggleBit;
            end
            default: out_if.rdy = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every presented word must coincide with out.rdy and match the
    // head of the expected queue.
    always @(negedge clk) begin
        if (reset_n && out_if.wr) begin
            monGot = {out_if.data, out_if.ctrl};
            checkOutput("out_wr_needs_rdy", 72'(out_if.rdy), 72'(1));
            if (logging) cycLog.push_back(cyc);
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_word: got %0h expected none", monGot);
            end else begin
                monWant = expQ.pop_front();
                checkOutput("out_word", 72'(monGot), 72'(monWant));
            end
        end
    end

    task automatic resetModel();
        modelLast   = 1'b1;
        modelCnt[0] = '0;
        modelCnt[1] = '0;
        expQ.delete();
        copy0.delete();
        copy1.delete();
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        resetModel();
    endtask

    task automatic makePacket(input int src, input int nHdr, input int nPay, input logic [7:0] eopCtrl);
        word_t w;
        for (int k = 0; k < nHdr + nPay + 1; k++) begin
            w.data     = {$urandom, $urandom};
            w.data[63] = src[0];
            if (k == 0)                w.ctrl = 8'hFF;
            else if (k < nHdr)         w.ctrl = 8'($urandom_range(1, 255));
            else if (k < nHdr + nPay)  w.ctrl = 8'h00;
            else                       w.ctrl = eopCtrl;
            if (src == 0) begin stage0.push_back(w); copy0.push_back(w); end
            else          begin stage1.push_back(w); copy1.push_back(w); end
        end
    endtask

    // Reference model: whole packets leave in grant order; counters wrap at 32 bits.
    task automatic expectPacket(input int src);
        if (src == 0) begin
            foreach (copy0[k]) expQ.push_back(copy0[k]);
            copy0.delete();
        end else begin
            foreach (copy1[k]) expQ.push_back(copy1[k]);
            copy1.delete();
        end
        modelCnt[src] = modelCnt[src] + 32'd1;
        modelLast     = src[0];
    endtask

    task automatic expectRound(input bit has0, input bit has1);
        int first;
        if (has0 && has1) begin
`ifdef TCP_ARB_STRICT_PRIO_EN
            first = 1;
`else
            first = modelLast ? 0 : 1;
`endif
            expectPacket(first);
            expectPacket(1 - first);
        end else if (has0) begin
            expectPacket(0);
        end else if (has1) begin
            expectPacket(1);
        end
    endtask

    // Drive staged words, one per cycle per input; input 1 starts delay1 cycles late.
    task automatic applyStimulus(input int delay1);
        word_t w;
        int    i;
        i = 0;
        while (stage0.size() > 0 || stage1.size() > 0) begin
            @(posedge clk);
            #1;
            if (i == 0) startCyc = cyc;
            if (stage0.size() > 0) begin
                w = stage0.pop_front();
                in0_if.data = w.data; in0_if.ctrl = w.ctrl; in0_if.wr = 1'b1;
            end else begin
                in0_if.wr = 1'b0;
            end
            if (i >= delay1 && stage1.size() > 0) begin
                w = stage1.pop_front();
                in1_if.data = w.data; in1_if.ctrl = w.ctrl; in1_if.wr = 1'b1;
            end else begin
                in1_if.wr = 1'b0;
            end
            i++;
        end
        @(posedge clk);
        #1;
        in0_if.wr = 1'b0;
        in1_if.wr = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (expQ.size() > 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        checkOutput(name, 72'(expQ.size()), 72'(0));
        expQ.delete();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic checkCounters(input string name);
        checkOutput({name, "_cnt0"}, 72'(cnt0), 72'(modelCnt[0]));
        checkOutput({name, "_cnt1"}, 72'(cnt1), 72'(modelCnt[1]));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit has0, has1;
        word_t junk;
        in0_if.wr = 1'b0; in0_if.data = '0; in0_if.ctrl = '0;
        in1_if.wr = 1'b0; in1_if.data = '0; in1_if.ctrl = '0;
        doReset();
        #1;
        checkOutput("reset_out_wr", 72'(out_if.wr), 72'(0));
        checkOutput("reset_in0_rdy", 72'(in0_if.rdy), 72'(1));
        checkOutput("reset_in1_rdy", 72'(in1_if.rdy), 72'(1));
        checkCounters("reset");

        // Single 5-word packet: output in cycles N+2..N+6.
        $display("[TB] single packet latency");
        rdyMode = 1;
        @(posedge clk);
        makePacket(0, 1, 3, 8'h04);
        expectPacket(0);
        cycLog.delete();
        logging = 1'b1;
        applyStimulus(0);
        drain("single_drain");
        logging = 1'b0;
        checkOutput("single_nwords", 72'(cycLog.size()), 72'(5));
        if (cycLog.size() == 5) begin
            checkOutput("single_first_cycle", 72'(cycLog[0]), 72'(startCyc + 2));
            checkOutput("single_last_cycle", 72'(cycLog[4]), 72'(startCyc + 6));
        end
        checkCounters("single");

        // Tie right after reset: input 0 first (input 1 in strict mode), one bubble.
        $display("[TB] tie after reset");
        doReset();
        makePacket(0, 1, 2, 8'h08);
        makePacket(1, 1, 2, 8'h02);
        expectRound(1'b1, 1'b1);
        cycLog.delete();
        logging = 1'b1;
        applyStimulus(0);
        drain("tie_drain");
        logging = 1'b0;
        checkOutput("tie_nwords", 72'(cycLog.size()), 72'(8));
        if (cycLog.size() == 8) begin
            checkOutput("tie_pkt_a_burst", 72'(cycLog[3] - cycLog[0]), 72'(3));
            checkOutput("tie_bubble", 72'(cycLog[4] - cycLog[3]), 72'(2));
            checkOutput("tie_pkt_b_burst", 72'(cycLog[7] - cycLog[4]), 72'(3));
        end
        checkCounters("tie");

        // Alternating out_rdy while input 1 waits behind input 0's packet.
        $display("[TB] toggled out_rdy stall");
        toggleBit = 1'b1;
        rdyMode = 2;
        makePacket(0, 1, 3, 8'h04);
        makePacket(1, 1, 2, 8'h01);
        expectPacket(0);
        expectPacket(1);
        applyStimulus(1);
        drain("stall_drain");
        checkCounters("stall");

        // Nine writes into a stalled input: eighth fills it, ninth dropped.
        $display("[TB] overflow");
        rdyMode = 0;
        repeat (2) @(posedge clk);
        makePacket(0, 1, 6, 8'h04);
        junk.data = 64'h0BAD_0BAD_0BAD_0BAD;
        junk.ctrl = 8'hFF;
        stage0.push_back(junk);
        expectPacket(0);
        applyStimulus(0);
        checkOutput("overflow_in0_rdy_low", 72'(in0_if.rdy), 72'(0));
        checkOutput("overflow_in1_rdy", 72'(in1_if.rdy), 72'(1));
        rdyMode = 1;
        drain("overflow_drain");
        checkOutput("overflow_in0_rdy_back", 72'(in0_if.rdy), 72'(1));
        checkCounters("overflow");

        // Random rounds: random packet shapes, random subset of inputs, random out_rdy.
        $display("[TB] random rounds");
        for (int r = 0; r < 20; r++) begin
            has0 = 1'($urandom_range(0, 1));
            has1 = has0 ? 1'($urandom_range(0, 1)) : 1'b1;
            if (has0) makePacket(0, $urandom_range(1, 2), $urandom_range(1, 4), 8'($urandom_range(1, 255)));
            if (has1) makePacket(1, $urandom_range(1, 2), $urandom_range(1, 4), 8'($urandom_range(1, 255)));
            rdyMode = 0;
            @(posedge clk);
            expectRound(has0, has1);
            applyStimulus(0);
            rdyMode = 3;
            drain("random_drain");
        end
        checkCounters("random");

        // Asynchronous reset pulse in the middle of a packet.
        $display("[TB] reset mid-packet");
        rdyMode = 0;
        @(posedge clk);
        makePacket(0, 1, 4, 8'h02);
        expectPacket(0);
        applyStimulus(0);
        rdyMode = 1;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b0;
        resetModel();
        #1;
        checkOutput("midreset_out_wr", 72'(out_if.wr), 72'(0));
        checkOutput("midreset_in0_rdy", 72'(in0_if.rdy), 72'(1));
        checkOutput("midreset_in1_rdy", 72'(in1_if.rdy), 72'(1));
        checkCounters("midreset");
        @(posedge clk);
        #4 reset_n = 1'b1;
        makePacket(1, 2, 3, 8'h10);
        expectPacket(1);
        applyStimulus(0);
        drain("postreset_drain");
        checkCounters("postreset");

        // Counter wrap on input 1.
        $display("[TB] counter wrap");
        force dut.pkt_cnt1 = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.pkt_cnt1;
        modelCnt[1] = 32'hFFFF_FFFF;
        checkOutput("wrap_preset", 72'(cnt1), 72'(modelCnt[1]));
        makePacket(1, 1, 2, 8'h04);
        expectPacket(1);
        applyStimulus(0);
        drain("wrap_drain");
        checkOutput("wrap_cnt1_zero", 72'(cnt1), 72'(0));
        checkCounters("wrap");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
